layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
Controller that sequences one fully-connected neural-net layer over a shared multiply-accumulate (MAC) datapath. It walks an input index and a neuron index, and issues the following to the MAC and activation stages:
- accumulator clear
- accumulate enable
- activation enable
It presents one result per neuron through a valid/ready handshake and pulses done at the end of the layer. Its index counters are wrap-limited counters with clear and increment control, in the same style as the existing small counters.

Parameters:
N_INPUTS, 4, inputs per neuron (>=1); accumulate cycles per neuron
N_NEURONS, 4, neurons per layer (>=1)
IDX_W, 2, width of input_idx; must satisfy 2**IDX_W >= N_INPUTS, minimum 1
NRN_W, 2, width of neuron_idx; must satisfy 2**NRN_W >= N_NEURONS, minimum 1

Ports:
clock  in  1  rising-edge clock
clear  in  1  reset: synchronous, active-high
en  in  1  advance enable; gates IDLE start, CLR_ACC, ACCUM, ACTIVATE
start  in  1  layer start request, sampled in IDLE only
out_ready  in  1  downstream accepts current neuron result
busy  out  1  high in every state except IDLE
input_idx  out  IDX_W  weight/input select for MAC (registered)
neuron_idx  out  NRN_W  current neuron (registered)
acc_clear  out  1  zero the accumulator
acc_en  out  1  accumulate input_idx term this cycle
act_en  out  1  latch activation of accumulator
out_valid  out  1  result for neuron_idx available
done  out  1  one-cycle pulse, layer complete

Behaviour:
- All state registers update on the clock rising edge. Outputs decode combinationally from the registered state and en. There are no other combinational paths.
- clear=1 (highest priority, any state, including mid-layer): next state IDLE; input_idx=0; neuron_idx=0.
- Output values while in IDLE after reset: busy=0, acc_clear=0, acc_en=0, act_en=0, out_valid=0, done=0.
- FSM states: IDLE, CLR_ACC, ACCUM, ACTIVATE, OUTPUT, DONE.
- IDLE: if start&en, then go to CLR_ACC with input_idx=0 and neuron_idx=0. Otherwise hold.
- CLR_ACC: acc_clear=en. If en, go to ACCUM. Otherwise hold.
- ACCUM: acc_en=en.
  - If en and input_idx==N_INPUTS-1: set input_idx=0 and go to ACTIVATE.
  - Else if en: input_idx+1.
  - en=0: stall; indices and state hold; acc_en=0.
- ACTIVATE: act_en=en. If en, go to OUTPUT.
- OUTPUT: out_valid=1, not gated by en. neuron_idx is stable while valid.
  - Transfer occurs on out_valid&out_ready.
  - On transfer with neuron_idx==N_NEURONS-1: go to DONE.
  - On transfer otherwise: neuron_idx+1 and go to CLR_ACC.
  - No transfer: hold.
- DONE: done=1 for exactly one cycle. Next state IDLE; neuron_idx=0.
- start outside IDLE, including in DONE, is ignored. start is not queued.
- Index counters never exceed N_INPUTS-1 or N_NEURONS-1; they wrap to 0 only as specified above.
- Arithmetic: all increments are unsigned, truncated to IDX_W or NRN_W bits.
- N_INPUTS=1: ACCUM lasts exactly one enabled cycle.
- Latency with en=1 and out_ready=1:
  - start is sampled at edge 0; CLR_ACC occupies cycle 1.
  - Neuron n is in OUTPUT in cycle (N_INPUTS+3)*(n+1).
  - DONE occurs in cycle N_NEURONS*(N_INPUTS+3)+1.
- acc_clear, acc_en, act_en and out_valid are mutually exclusive. busy=1 in DONE.

Test Plan:
- Nominal 4x4 run, en=1, out_ready=1, start pulse at edge 0:
  - acc_clear in cycles 1,8,15,22.
  - acc_en with input_idx 0..3 in cycles 2-5.
  - out_valid with neuron_idx 0..3 in cycles 7,14,21,28.
  - done in cycle 29; busy=0 in cycle 30.
- Back-pressure: out_ready=0 for 5 cycles at neuron 1 OUTPUT:
  - out_valid stays high and neuron_idx stays 1.
  - The following CLR_ACC is delayed 5 cycles; done is at cycle 34.
- en stall: en=0 for 3 cycles while input_idx=2 in ACCUM:
  - acc_en=0 and input_idx stays 2 for those cycles.
  - The accumulate sequence then resumes at 2,3; total shift is +3 cycles.
- Mid-layer clear: assert clear in ACCUM of neuron 2:
  - Next cycle is IDLE; all outputs are 0 and both indices are 0.
  - A subsequent start restarts from neuron 0.
- start ignored when busy: pulse start during ACCUM and during DONE:
  - No restart; exactly one done pulse; IDLE afterwards.
- Edge sizes N_INPUTS=1, N_NEURONS=1, IDX_W=1, NRN_W=1:
  - Sequence is CLR_ACC, ACCUM, ACTIVATE, OUTPUT, DONE in cycles 1-5.
  - input_idx and neuron_idx stay 0.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer over a shared MAC datapath: walks the input and neuron
// indices and issues accumulator clear, accumulate and activate strobes, one result per neuron.
module layer_sequencer #(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned NRN_W     = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             start,
  input  logic             out_ready,
  output logic             busy,
  output logic [IDX_W-1:0] input_idx,
  output logic [NRN_W-1:0] neuron_idx,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             act_en,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StClrAcc,
    StAccum,
    StActivate,
    StOutput,
    StDone
  } state_t;

  localparam logic [IDX_W-1:0] LastInput  = IDX_W'(N_INPUTS - 1);
  localparam logic [NRN_W-1:0] LastNeuron = NRN_W'(N_NEURONS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_input_idx;
  logic [NRN_W-1:0] r_neuron_idx;
  logic             w_transfer;

  assign w_transfer = (r_state == StOutput) && out_ready;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= StIdle;
      r_input_idx  <= '0;
      r_neuron_idx <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start && en) begin
            r_state      <= StClrAcc;
            r_input_idx  <= '0;
            r_neuron_idx <= '0;
          end
        end
        StClrAcc: begin
          if (en) r_state <= StAccum;
        end
        StAccum: begin
          if (en) begin
            if (r_input_idx == LastInput) begin
              r_input_idx <= '0;
              r_state     <= StActivate;
            end else begin
              r_input_idx <= r_input_idx + IDX_W'(1);
            end
          end
        end
        StActivate: begin
          if (en) r_state <= StOutput;
        end
        StOutput: begin
          // Output handshake is deliberately not gated by en.
          if (w_transfer) begin
            if (r_neuron_idx == LastNeuron) begin
              r_state <= StDone;
            end else begin
              r_neuron_idx <= r_neuron_idx + NRN_W'(1);
              r_state      <= StClrAcc;
            end
          end
        end
        StDone: begin
          r_state      <= StIdle;
          r_neuron_idx <= '0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy       = (r_state != StIdle);
  assign input_idx  = r_input_idx;
  assign neuron_idx = r_neuron_idx;
  assign acc_clear  = (r_state == StClrAcc) && en;
  assign acc_en     = (r_state == StAccum) && en;
  assign act_en     = (r_state == StActivate) && en;
  assign out_valid  = (r_state == StOutput);
  assign done       = (r_state == StDone);

endmodule
